// File: rtl/matvec_mac_engine_if.sv
// matvec_mac_engine_if
//   Groups the control handshake, the three operand ROM ports and the result
//   stream of matvec_mac_engine.
//   master : engine side. Drives addresses, status, results and statistics.
//   slave  : environment side. Drives start/c_en and the ROM read data.
//   Signals:
//     start, c_en              run request and "add c" select
//     busy, done               run status (done is a level)
//     a_addr / a_rd_data       A ROM, LANES elements per word
//     x_addr / x_rd_data       x ROM, LANES elements per word
//     c_addr / c_rd_data       c ROM, one element per word
//     y_valid, y_index, y_data result stream, one strobe per row
//     checksum, cycle_count    run statistics
interface matvec_mac_engine_if #(
    parameter int unsigned ROWS  = 128,
    parameter int unsigned COLS  = 128,
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 8
);
    localparam int unsigned B    = COLS / LANES;
    localparam int unsigned ACCW = 2 * DW + $clog2(COLS) + 1;
    localparam int unsigned AAW  = (ROWS * B > 1) ? $clog2(ROWS * B) : 1;
    localparam int unsigned XAW  = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned RAW  = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                  start;
    logic                  c_en;
    logic                  busy;
    logic                  done;
    logic [AAW-1:0]        a_addr;
    logic [LANES*DW-1:0]   a_rd_data;
    logic [XAW-1:0]        x_addr;
    logic [LANES*DW-1:0]   x_rd_data;
    logic [RAW-1:0]        c_addr;
    logic [DW-1:0]         c_rd_data;
    logic                  y_valid;
    logic [RAW-1:0]        y_index;
    logic [ACCW-1:0]       y_data;
    logic [31:0]           checksum;
    logic [31:0]           cycle_count;

    modport master (
        input  start, c_en, a_rd_data, x_rd_data, c_rd_data,
        output busy, done, a_addr, x_addr, c_addr, y_valid, y_index, y_data,
               checksum, cycle_count
    );

    modport slave (
        output start, c_en, a_rd_data, x_rd_data, c_rd_data,
        input  busy, done, a_addr, x_addr, c_addr, y_valid, y_index, y_data,
               checksum, cycle_count
    );
endinterface

// File: rtl/matvec_mac_engine.sv
// matvec_mac_engine
//   Computes y = A*x (+ c) for a ROWS x COLS matrix, LANES products per beat,
//   with operands read from external 1-cycle-latency synchronous ROMs.
//   Ports:
//     CLOCK_50  clock, rising edge
//     KEY0      synchronous active-low reset
//     bus       matvec_mac_engine_if.master (handshake, ROM ports, results)
//   Pipeline: beat issued in cycle s -> ROM data in s+1 -> accumulated at the
//   end of s+1; the last beat of a row produces y at the end of s+1.
module matvec_mac_engine #(
    parameter int unsigned ROWS  = 128,
    parameter int unsigned COLS  = 128,
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 8
) (
    input logic                 CLOCK_50,
    input logic                 KEY0,
    matvec_mac_engine_if.master bus
);
    localparam int unsigned B    = COLS / LANES;
    localparam int unsigned ACCW = 2 * DW + $clog2(COLS) + 1;
    localparam int unsigned AAW  = (ROWS * B > 1) ? $clog2(ROWS * B) : 1;
    localparam int unsigned XAW  = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned RAW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [XAW-1:0] LastBeat = XAW'(B - 1);
    localparam logic [RAW-1:0] LastRow  = RAW'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [AAW-1:0]  a_addr_q, a_addr_d;
    logic [XAW-1:0]  beat_q, beat_d;          // doubles as x_addr
    logic [RAW-1:0]  row_q, row_d;            // doubles as c_addr
    logic            c_en_q, c_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    // Tag of the beat whose ROM data is on the read buses this cycle.
    logic            d_vld_q, d_vld_d;
    logic            d_first_q, d_first_d;
    logic            d_last_q, d_last_d;
    logic [RAW-1:0]  d_row_q, d_row_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            y_valid_q, y_valid_d;
    logic [RAW-1:0]  y_index_q, y_index_d;
    logic [ACCW-1:0] y_data_q, y_data_d;
    logic [31:0]     checksum_q, checksum_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic [ACCW-1:0] lane_sum;
    logic [ACCW-1:0] row_sum;

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane_sum = lane_sum + ACCW'(bus.a_rd_data[k*DW +: DW])
                                * ACCW'(bus.x_rd_data[k*DW +: DW]);
        end
        // Beat 0 restarts the row instead of adding to the previous row.
        row_sum = (d_first_q ? '0 : acc_q) + lane_sum;
    end

    always_comb begin
        state_d       = state_q;
        a_addr_d      = a_addr_q;
        beat_d        = beat_q;
        row_d         = row_q;
        c_en_d        = c_en_q;
        busy_d        = busy_q;
        done_d        = done_q;
        d_vld_d       = 1'b0;
        d_first_d     = d_first_q;
        d_last_d      = d_last_q;
        d_row_d       = d_row_q;
        acc_d         = acc_q;
        y_valid_d     = 1'b0;
        y_index_d     = y_index_q;
        y_data_d      = y_data_q;
        checksum_d    = checksum_q;
        cycle_count_d = cycle_count_q;

        if (busy_q) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        if (y_valid_q) begin
            checksum_d = checksum_q + 32'(y_data_q);
        end

        if (d_vld_q) begin
            if (d_last_q) begin
                y_data_d  = row_sum + (c_en_q ? ACCW'(bus.c_rd_data) : '0);
                y_index_d = d_row_q;
                y_valid_d = 1'b1;
            end else begin
                acc_d = row_sum;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d       = StRun;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    c_en_d        = bus.c_en;
                    checksum_d    = '0;
                    cycle_count_d = '0;
                    a_addr_d      = '0;
                    beat_d        = '0;
                    row_d         = '0;
                end
            end
            StRun: begin
                d_vld_d   = 1'b1;
                d_first_d = (beat_q == '0);
                d_last_d  = (beat_q == LastBeat);
                d_row_d   = row_q;
                if (beat_q == LastBeat) begin
                    if (row_q == LastRow) begin
                        // Addresses hold on the final beat.
                        state_d = StDrain;
                    end else begin
                        beat_d   = '0;
                        row_d    = row_q + 1'b1;
                        a_addr_d = a_addr_q + 1'b1;
                    end
                end else begin
                    beat_d   = beat_q + 1'b1;
                    a_addr_d = a_addr_q + 1'b1;
                end
            end
            StDrain: begin
                // Earlier rows may still strobe here when B is small.
                if (y_valid_q && (y_index_q == LastRow)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state_q       <= StIdle;
            a_addr_q      <= '0;
            beat_q        <= '0;
            row_q         <= '0;
            c_en_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            d_vld_q       <= 1'b0;
            d_first_q     <= 1'b0;
            d_last_q      <= 1'b0;
            d_row_q       <= '0;
            acc_q         <= '0;
            y_valid_q     <= 1'b0;
            y_index_q     <= '0;
            y_data_q      <= '0;
            checksum_q    <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            a_addr_q      <= a_addr_d;
            beat_q        <= beat_d;
            row_q         <= row_d;
            c_en_q        <= c_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            d_vld_q       <= d_vld_d;
            d_first_q     <= d_first_d;
            d_last_q      <= d_last_d;
            d_row_q       <= d_row_d;
            acc_q         <= acc_d;
            y_valid_q     <= y_valid_d;
            y_index_q     <= y_index_d;
            y_data_q      <= y_data_d;
            checksum_q    <= checksum_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.a_addr      = a_addr_q;
    assign bus.x_addr      = beat_q;
    assign bus.c_addr      = row_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.y_valid     = y_valid_q;
    assign bus.y_index     = y_index_q;
    assign bus.y_data      = y_data_q;
    assign bus.checksum    = checksum_q;
    assign bus.cycle_count = cycle_count_q;
endmodule
